// File: rtl/sim_lane_responder.sv
// Per-lane memory-request responder: each lane echoes accepted requests in order after a fixed delay.
// Latency: a response becomes valid LATENCY-1 edges after the accepting edge and is consumed LATENCY edges after it.
// Backpressure: a_ready drops only when a lane holds DEPTH entries; d_valid and d_* hold stable until d_ready.
module sim_lane_responder #(
    parameter int NUM_LANES     = 4,
    parameter int DATA_WIDTH    = 64,
    parameter int LOGSIZE_WIDTH = 8,
    parameter int DEPTH         = 4,
    parameter int LATENCY       = 2
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic [NUM_LANES-1:0]               a_valid,
    output logic [NUM_LANES-1:0]               a_ready,
    input  logic [DATA_WIDTH*NUM_LANES-1:0]    a_address,
    input  logic [NUM_LANES-1:0]               a_is_store,
    input  logic [LOGSIZE_WIDTH*NUM_LANES-1:0] a_size,
    input  logic [DATA_WIDTH*NUM_LANES-1:0]    a_data,
    output logic [NUM_LANES-1:0]               d_valid,
    input  logic [NUM_LANES-1:0]               d_ready,
    output logic [NUM_LANES-1:0]               d_is_store,
    output logic [LOGSIZE_WIDTH*NUM_LANES-1:0] d_size,
    output logic [DATA_WIDTH*NUM_LANES-1:0]    d_address,
    output logic                               inflight,
    output logic [NUM_LANES-1:0]               size_error
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int TW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [LOGSIZE_WIDTH-1:0] MAX_SIZE = LOGSIZE_WIDTH'($clog2(DATA_WIDTH / 8));
    localparam logic [TW-1:0] TIMER_INIT = TW'(LATENCY - 1);

    logic [NUM_LANES-1:0] nonempty;

    // Store payload is accepted but never returned, so it is only folded away here.
    logic unused_data;
    assign unused_data = ^a_data;

    assign inflight = |nonempty;

    genvar g;
    generate
        for (g = 0; g < NUM_LANES; g++) begin : g_lane
            logic [DATA_WIDTH-1:0]    mem_address [DEPTH];
            logic [DEPTH-1:0]         mem_is_store;
            logic [LOGSIZE_WIDTH-1:0] mem_size    [DEPTH];
            logic [TW-1:0]            mem_timer   [DEPTH];
            logic [PW-1:0]            wr_ptr;
            logic [PW-1:0]            rd_ptr;
            logic [PW-1:0]            count;
            logic [AW-1:0]            wr_idx;
            logic [AW-1:0]            rd_idx;
            logic                     enq;
            logic                     deq;
            logic                     err;

            assign wr_idx = wr_ptr[AW-1:0];
            assign rd_idx = rd_ptr[AW-1:0];

            // Ready is purely occupancy based, so a full lane never accepts even if it dequeues.
            assign a_ready[g]  = (count != PW'(DEPTH));
            assign nonempty[g] = (count != '0);
            assign d_valid[g]  = nonempty[g] && (mem_timer[rd_idx] == '0);
            assign enq         = a_valid[g] && a_ready[g];
            assign deq         = d_valid[g] && d_ready[g];

            assign d_is_store[g]                              = mem_is_store[rd_idx];
            assign d_size[LOGSIZE_WIDTH*g +: LOGSIZE_WIDTH]   = mem_size[rd_idx];
            assign d_address[DATA_WIDTH*g +: DATA_WIDTH]      = mem_address[rd_idx];
            assign size_error[g]                              = err;

            // Pointer and occupancy bookkeeping; pointers wrap naturally modulo 2*DEPTH.
            always_ff @(posedge clock or negedge reset) begin
                if (!reset) begin
                    wr_ptr <= '0;
                    rd_ptr <= '0;
                    count  <= '0;
                end else begin
                    if (enq) wr_ptr <= wr_ptr + PW'(1);
                    if (deq) rd_ptr <= rd_ptr + PW'(1);
                    case ({enq, deq})
                        2'b10:   count <= count + PW'(1);
                        2'b01:   count <= count - PW'(1);
                        default: count <= count;
                    endcase
                end
            end

            // Entry storage: new entries load the full delay, stored entries count down to zero.
            always_ff @(posedge clock or negedge reset) begin
                if (!reset) begin
                    mem_is_store <= '0;
                    for (int i = 0; i < DEPTH; i++) begin
                        mem_address[i] <= '0;
                        mem_size[i]    <= '0;
                        mem_timer[i]   <= '0;
                    end
                end else begin
                    for (int i = 0; i < DEPTH; i++) begin
                        if (enq && (wr_idx == AW'(i))) begin
                            mem_address[i]  <= a_address[DATA_WIDTH*g +: DATA_WIDTH];
                            mem_is_store[i] <= a_is_store[g];
                            mem_size[i]     <= a_size[LOGSIZE_WIDTH*g +: LOGSIZE_WIDTH];
                            mem_timer[i]    <= TIMER_INIT;
                        end else if (mem_timer[i] != '0) begin
                            mem_timer[i] <= mem_timer[i] - TW'(1);
                        end
                    end
                end
            end

            // Sticky flag for accepted requests wider than the data bus; only reset clears it.
            always_ff @(posedge clock or negedge reset) begin
                if (!reset) begin
                    err <= 1'b0;
                end else if (enq && (a_size[LOGSIZE_WIDTH*g +: LOGSIZE_WIDTH] > MAX_SIZE)) begin
                    err <= 1'b1;
                end
            end
        end
    endgenerate

endmodule
